// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32 fetch sequencer, one outstanding imem request, single-entry
// decode buffer, redirect squash and sticky fault on bus error or misaligned target.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_ctrl,
  input  logic [31:0] pc_br,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic [31:0] pc,
  output logic        fault
);
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, FAULT} state_t;
  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc, r_if_pc, r_if_instr;
  logic        r_squash, w_squash, w_latch, w_br, w_hs;
  assign w_br           = br_ctrl & (r_state != FAULT);
  assign imem_req_valid = (r_state == REQ) & ~stall;
  assign w_hs           = imem_req_valid & imem_req_ready;
  assign imem_req_addr  = r_pc;
  assign pc             = r_pc;
  assign if_valid       = r_state == HOLD;
  assign if_pc          = r_if_pc;
  assign if_instr       = r_if_instr;
  assign fault          = r_state == FAULT;
  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_squash = r_squash;
    w_latch  = 1'b0;
    case (r_state)
      BOOT: w_state = REQ;
      REQ:  w_state = w_hs ? WAIT : REQ;
      WAIT: if (imem_rsp_valid) begin
        w_squash = 1'b0;
        w_latch  = ~r_squash & ~imem_rsp_err;
        w_state  = r_squash ? REQ : imem_rsp_err ? FAULT : HOLD;
      end
      HOLD: if (if_ready) begin
        w_pc    = r_pc + 32'd4;
        w_state = REQ;
      end
      default: ;
    endcase
    // a redirect leaves a request in flight only if one was accepted and not yet answered
    if (w_br) begin
      w_pc     = pc_br;
      w_latch  = 1'b0;
      w_squash = ((r_state == WAIT) & ~imem_rsp_valid) | ((r_state == REQ) & w_hs);
      w_state  = (pc_br[1:0] != 2'b00) ? FAULT : w_squash ? WAIT : REQ;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_squash   <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_instr <= 32'h0;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_squash <= w_squash;
      if (w_latch) begin
        r_if_pc    <= r_pc;
        r_if_instr <= imem_rsp_data;
      end
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table, hand sequences for corner cases, and
// randomized traffic against a transaction-level fetch model.
module tb_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0;
  logic        clk = 1'b0, rst = 1'b1;
  logic        br_ctrl, stall, imem_req_ready, imem_rsp_valid, imem_rsp_err, if_ready;
  logic [31:0] pc_br, imem_rsp_data;
  logic        imem_req_valid, if_valid, fault;
  logic [31:0] imem_req_addr, if_pc, if_instr, pc;
  int n_cmp = 0, n_bad = 0;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .br_ctrl(br_ctrl), .pc_br(pc_br), .stall(stall),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
    .pc(pc), .fault(fault)
  );

  always #5 clk = ~clk;

  // ctl = {br_ctrl, stall, req_ready, if_ready, rsp_valid, rsp_err}; ex = {req_valid, if_valid, fault}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] pbr;
    logic [2:0]  ex;
    logic [31:0] epc, eipc, eins;
  } row_t;
  row_t tbl [29];

  // fetch model state: booting, request outstanding, outstanding one is stale, buffer full, faulted
  logic        m_boot, m_out, m_stale, m_buf, m_fault;
  logic [31:0] m_pc, m_ipc, m_ins;
  logic        mp, me;
  int          mc;
  logic [31:0] md;

  function automatic row_t mk(logic [5:0] c, logic [31:0] p, logic [2:0] x,
                              logic [31:0] a, logic [31:0] b, logic [31:0] d);
    row_t r;
    r.ctl = c; r.pbr = p; r.ex = x; r.epc = a; r.eipc = b; r.eins = d;
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", n, $time, a, e);
    end
  endtask

  task automatic step(input row_t r);
    {br_ctrl, stall, imem_req_ready, if_ready, imem_rsp_valid, imem_rsp_err} = r.ctl;
    pc_br = r.pbr;
    imem_rsp_data = r.epc ^ 32'h13;
    #1;
    chk("req_valid", 32'(imem_req_valid), 32'(r.ex[2]));
    chk("req_addr", imem_req_addr, r.epc);
    chk("pc", pc, r.epc);
    chk("if_valid", 32'(if_valid), 32'(r.ex[1]));
    chk("if_pc", if_pc, r.eipc);
    chk("if_instr", if_instr, r.eins);
    chk("fault", 32'(fault), 32'(r.ex[0]));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic m_reset();
    m_boot = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_buf = 1'b0; m_fault = 1'b0;
    m_pc = RST_PC; m_ipc = 32'h0; m_ins = 32'h0;
    mp = 1'b0; mc = 0; md = 32'h0; me = 1'b0;
  endtask

  task automatic do_reset();
    {br_ctrl, stall, imem_req_ready, if_ready, imem_rsp_valid, imem_rsp_err} = 6'b0;
    pc_br = 32'h0;
    imem_rsp_data = 32'h0;
    rst = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rnd_cycle();
    logic [31:0] t;
    logic rv, hs, e_req, br;
    t = $urandom;
    br_ctrl = ($urandom_range(0, 7) == 0);
    pc_br = {t[31:2], ($urandom_range(0, 19) == 0) ? 2'b10 : 2'b00};
    stall = ($urandom_range(0, 3) == 0);
    imem_req_ready = ($urandom_range(0, 2) != 0);
    if_ready = ($urandom_range(0, 2) != 0);
    rv = mp && mc == 0;
    imem_rsp_valid = rv;
    imem_rsp_data = rv ? md : $urandom;
    imem_rsp_err = rv ? me : 1'($urandom_range(0, 1));
    #1;
    e_req = !m_boot && !m_out && !m_buf && !m_fault && !stall;
    chk("r_req_valid", 32'(imem_req_valid), 32'(e_req));
    chk("r_req_addr", imem_req_addr, m_pc);
    chk("r_if_valid", 32'(if_valid), 32'(m_buf));
    if (m_buf) begin
      chk("r_if_pc", if_pc, m_ipc);
      chk("r_if_instr", if_instr, m_ins);
    end
    chk("r_fault", 32'(fault), 32'(m_fault));
    br = br_ctrl && !m_fault;
    hs = e_req && imem_req_ready;
    if (!m_fault) begin
      if (br) begin
        m_pc = pc_br; m_boot = 1'b0; m_buf = 1'b0;
        m_out = (m_out && !rv) || hs;
        m_stale = m_out;
        if (pc_br[1:0] != 2'b00) m_fault = 1'b1;
      end else if (m_boot) m_boot = 1'b0;
      else if (hs) m_out = 1'b1;
      else if (m_out && rv) begin
        m_out = 1'b0;
        if (m_stale) m_stale = 1'b0;
        else if (imem_rsp_err) m_fault = 1'b1;
        else begin m_buf = 1'b1; m_ipc = m_pc; m_ins = imem_rsp_data; end
      end else if (m_buf && if_ready) begin
        m_buf = 1'b0;
        m_pc = m_pc + 32'd4;
      end
    end
    if (rv) mp = 1'b0;
    else if (mp) mc--;
    if (hs) begin
      mp = 1'b1; mc = $urandom_range(0, 2); md = $urandom; me = ($urandom_range(0, 11) == 0);
    end
    @(posedge clk);
    @(negedge clk);
    if (m_fault && $urandom_range(0, 3) == 0) do_reset();
  endtask

  initial begin
    {br_ctrl, stall, imem_req_ready, if_ready, imem_rsp_valid, imem_rsp_err} = 6'b0;
    pc_br = 32'h0;
    imem_rsp_data = 32'h0;
    tbl[0]  = mk(6'b001100, 32'h0,   3'b000, 32'h0,   32'h0,   32'h0);
    tbl[1]  = mk(6'b001100, 32'h0,   3'b100, 32'h0,   32'h0,   32'h0);
    tbl[2]  = mk(6'b001110, 32'h0,   3'b000, 32'h0,   32'h0,   32'h0);
    tbl[3]  = mk(6'b001100, 32'h0,   3'b010, 32'h0,   32'h0,   32'h13);
    tbl[4]  = mk(6'b001100, 32'h0,   3'b100, 32'h4,   32'h0,   32'h13);
    tbl[5]  = mk(6'b001110, 32'h0,   3'b000, 32'h4,   32'h0,   32'h13);
    tbl[6]  = mk(6'b001100, 32'h0,   3'b010, 32'h4,   32'h4,   32'h17);
    tbl[7]  = mk(6'b001100, 32'h0,   3'b100, 32'h8,   32'h4,   32'h17);
    tbl[8]  = mk(6'b101100, 32'h100, 3'b000, 32'h8,   32'h4,   32'h17);
    tbl[9]  = mk(6'b001100, 32'h0,   3'b000, 32'h100, 32'h4,   32'h17);
    tbl[10] = mk(6'b001110, 32'h0,   3'b000, 32'h100, 32'h4,   32'h17);
    tbl[11] = mk(6'b001100, 32'h0,   3'b100, 32'h100, 32'h4,   32'h17);
    tbl[12] = mk(6'b001110, 32'h0,   3'b000, 32'h100, 32'h4,   32'h17);
    tbl[13] = mk(6'b001100, 32'h0,   3'b010, 32'h100, 32'h100, 32'h113);
    tbl[14] = mk(6'b011100, 32'h0,   3'b000, 32'h104, 32'h100, 32'h113);
    tbl[15] = mk(6'b111100, 32'h40,  3'b000, 32'h104, 32'h100, 32'h113);
    tbl[16] = mk(6'b011100, 32'h0,   3'b000, 32'h40,  32'h100, 32'h113);
    tbl[17] = mk(6'b011100, 32'h0,   3'b000, 32'h40,  32'h100, 32'h113);
    tbl[18] = mk(6'b001100, 32'h0,   3'b100, 32'h40,  32'h100, 32'h113);
    tbl[19] = mk(6'b001110, 32'h0,   3'b000, 32'h40,  32'h100, 32'h113);
    tbl[20] = mk(6'b001100, 32'h0,   3'b010, 32'h40,  32'h40,  32'h53);
    tbl[21] = mk(6'b101100, 32'h200, 3'b100, 32'h44,  32'h40,  32'h53);
    tbl[22] = mk(6'b001110, 32'h0,   3'b000, 32'h200, 32'h40,  32'h53);
    tbl[23] = mk(6'b001100, 32'h0,   3'b100, 32'h200, 32'h40,  32'h53);
    tbl[24] = mk(6'b101110, 32'h300, 3'b000, 32'h200, 32'h40,  32'h53);
    tbl[25] = mk(6'b001100, 32'h0,   3'b100, 32'h300, 32'h40,  32'h53);
    tbl[26] = mk(6'b001110, 32'h0,   3'b000, 32'h300, 32'h40,  32'h53);
    tbl[27] = mk(6'b101100, 32'h80,  3'b010, 32'h300, 32'h300, 32'h313);
    tbl[28] = mk(6'b001100, 32'h0,   3'b100, 32'h80,  32'h300, 32'h313);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 29; i++) step(tbl[i]);
    // decode backpressure: buffer must hold steady and no request issued
    do_reset();
    step(mk(6'b001100, 32'h0, 3'b000, 32'h0, 32'h0, 32'h0));
    step(mk(6'b001100, 32'h0, 3'b100, 32'h0, 32'h0, 32'h0));
    step(mk(6'b001110, 32'h0, 3'b000, 32'h0, 32'h0, 32'h0));
    step(mk(6'b001100, 32'h0, 3'b010, 32'h0, 32'h0, 32'h13));
    step(mk(6'b001100, 32'h0, 3'b100, 32'h4, 32'h0, 32'h13));
    step(mk(6'b001110, 32'h0, 3'b000, 32'h4, 32'h0, 32'h13));
    for (int k = 0; k < 5; k++) step(mk(6'b001000, 32'h0, 3'b010, 32'h4, 32'h4, 32'h17));
    step(mk(6'b001100, 32'h0, 3'b010, 32'h4, 32'h4, 32'h17));
    step(mk(6'b001100, 32'h0, 3'b100, 32'h8, 32'h4, 32'h17));
    // bus error parks the block; redirects ignored until reset
    do_reset();
    step(mk(6'b101100, 32'hC,  3'b000, 32'h0, 32'h0, 32'h0));
    step(mk(6'b001100, 32'h0,  3'b100, 32'hC, 32'h0, 32'h0));
    step(mk(6'b001111, 32'h0,  3'b000, 32'hC, 32'h0, 32'h0));
    step(mk(6'b001100, 32'h0,  3'b001, 32'hC, 32'h0, 32'h0));
    step(mk(6'b101100, 32'h20, 3'b001, 32'hC, 32'h0, 32'h0));
    step(mk(6'b001100, 32'h0,  3'b001, 32'hC, 32'h0, 32'h0));
    do_reset();
    step(mk(6'b001100, 32'h0,   3'b000, 32'h0,   32'h0, 32'h0));
    step(mk(6'b100100, 32'h102, 3'b100, 32'h0,   32'h0, 32'h0));
    step(mk(6'b001100, 32'h0,   3'b001, 32'h102, 32'h0, 32'h0));
    // pc wraps from the top of the address space
    do_reset();
    step(mk(6'b101100, 32'hFFFF_FFFC, 3'b000, 32'h0,         32'h0,         32'h0));
    step(mk(6'b001100, 32'h0,         3'b100, 32'hFFFF_FFFC, 32'h0,         32'h0));
    step(mk(6'b001110, 32'h0,         3'b000, 32'hFFFF_FFFC, 32'h0,         32'h0));
    step(mk(6'b001100, 32'h0,         3'b010, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFEF));
    step(mk(6'b001100, 32'h0,         3'b100, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFEF));
    do_reset();
    for (int i = 0; i < 3000; i++) rnd_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
